e_mdu: RTL and testbench

- Execute-stage multiply/divide unit, with HI/LO registers, for the 5-stage MIPS pipeline.
- Runs mult/multu/div/divu as multi-cycle operations and performs mthi/mtlo writes.
- Returns HI or LO for mfhi/mflo.
- Produces the HI/LO busy flag consumed by the D-stage stall unit, which blocks any md/mt/mf instruction in D while this unit is busy.

---
 rtl/e_mdu_if.sv | 24 ++
 rtl/e_mdu.sv | 139 +++++++++++++
 tb/tb_e_mdu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// Execute-stage multiply/divide unit port bundle: operands, opcode and HI/LO results.
interface e_mdu_if;
   logic        md_en;
   logic [3:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        hilo_busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   // Pipeline side drives the instruction, the unit returns status and HI/LO.
   modport master (
      output md_en, md_op, A, B,
      input  busy, hilo_busy, hi, lo, md_out
   );

   // Multiply/divide unit side.
   modport slave (
      input  md_en, md_op, A, B,
      output busy, hilo_busy, hi, lo, md_out
   );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Result is computed at start and held in a pending register until the
// busy countdown expires, so HI/LO only change at the completion edge.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic   clk,
   input  logic   reset,
   e_mdu_if.slave mdu
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned CW   = 4;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t            r_state;
   logic              r_busy;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_pend_hi;
   logic [XLEN-1:0]   r_pend_lo;
   logic              r_pend_skip;

   logic              w_start;
   logic              w_is_mul;
   logic [2*XLEN-1:0] w_mul_a;
   logic [2*XLEN-1:0] w_mul_b;
   logic [2*XLEN-1:0] w_prod;
   logic              w_div_signed;
   logic [XLEN-1:0]   w_dvd;
   logic [XLEN-1:0]   w_dvs;
   logic [XLEN-1:0]   w_quo_mag;
   logic [XLEN-1:0]   w_rem_mag;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;

   assign w_start = mdu.md_en & ((mdu.md_op == OP_MULT) | (mdu.md_op == OP_MULTU) |
                                 (mdu.md_op == OP_DIV)  | (mdu.md_op == OP_DIVU));
   assign w_is_mul = (mdu.md_op == OP_MULT) | (mdu.md_op == OP_MULTU);

   // Full 64-bit product; signed form uses sign-extended operands, low 64 bits are exact.
   always_comb begin
      w_mul_a = {{XLEN{1'b0}}, mdu.A};
      w_mul_b = {{XLEN{1'b0}}, mdu.B};
      if (mdu.md_op == OP_MULT) begin
         w_mul_a = {{XLEN{mdu.A[XLEN-1]}}, mdu.A};
         w_mul_b = {{XLEN{mdu.B[XLEN-1]}}, mdu.B};
      end
      w_prod = w_mul_a * w_mul_b;
   end

   // Sign-magnitude division: avoids the INT_MIN / -1 trap and divide-by-zero in the model.
   always_comb begin
      w_div_signed = (mdu.md_op == OP_DIV);
      w_dvd        = (w_div_signed & mdu.A[XLEN-1]) ? XLEN'(-mdu.A) : mdu.A;
      w_dvs        = (w_div_signed & mdu.B[XLEN-1]) ? XLEN'(-mdu.B) : mdu.B;
      if (w_dvs == '0) begin
         w_dvs = XLEN'(1);
      end
      w_quo_mag = w_dvd / w_dvs;
      w_rem_mag = w_dvd % w_dvs;
      w_quo = (w_div_signed & (mdu.A[XLEN-1] ^ mdu.B[XLEN-1])) ? XLEN'(-w_quo_mag) : w_quo_mag;
      w_rem = (w_div_signed & mdu.A[XLEN-1]) ? XLEN'(-w_rem_mag) : w_rem_mag;
   end

   // Control FSM, HI/LO registers and pending result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_cnt       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_pend_hi   <= '0;
         r_pend_lo   <= '0;
         r_pend_skip <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  if (w_is_mul) begin
                     r_pend_hi   <= w_prod[2*XLEN-1:XLEN];
                     r_pend_lo   <= w_prod[XLEN-1:0];
                     r_pend_skip <= 1'b0;
                     r_cnt       <= CW'(MULT_CYCLES);
                  end else begin
                     r_pend_hi   <= w_rem;
                     r_pend_lo   <= w_quo;
                     r_pend_skip <= (mdu.B == '0);
                     r_cnt       <= CW'(DIV_CYCLES);
                  end
               end else if (mdu.md_en && mdu.md_op == OP_MTHI) begin
                  r_hi <= mdu.A;
               end else if (mdu.md_en && mdu.md_op == OP_MTLO) begin
                  r_lo <= mdu.A;
               end
            end
            S_RUN: begin
               if (r_cnt == CW'(1)) begin
                  if (!r_pend_skip) begin
                     r_hi <= r_pend_hi;
                     r_lo <= r_pend_lo;
                  end
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign mdu.busy      = r_busy;
   assign mdu.hilo_busy = r_busy | w_start;
   assign mdu.hi        = r_hi;
   assign mdu.lo        = r_lo;
   assign mdu.md_out    = (mdu.md_op == OP_MFHI) ? r_hi :
                          (mdu.md_op == OP_MFLO) ? r_lo : '0;
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: multiply/divide latency, HI/LO moves, flush and async reset.
module tb_e_mdu;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   e_mdu_if u_if ();

   e_mdu #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (u_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it on mismatch.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      u_if.md_en = en;
      u_if.md_op = op;
      u_if.A     = a;
      u_if.B     = b;
   endtask

   // Issue a start, check busy/hilo_busy over n cycles with HI/LO held, then the result.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] old_hi, input logic [31:0] old_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      drive(1'b1, op, a, b);
      #1;
      check({tag, ".hilo_busy_start"}, 32'(u_if.hilo_busy), 32'd1);
      check({tag, ".busy_start"}, 32'(u_if.busy), 32'd0);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      for (int i = 0; i < n; i++) begin
         check({tag, ".busy_run"}, 32'(u_if.busy), 32'd1);
         check({tag, ".hilo_busy_run"}, 32'(u_if.hilo_busy), 32'd1);
         check({tag, ".hi_hold"}, u_if.hi, old_hi);
         check({tag, ".lo_hold"}, u_if.lo, old_lo);
         tick();
      end
      check({tag, ".busy_done"}, 32'(u_if.busy), 32'd0);
      check({tag, ".hilo_busy_done"}, 32'(u_if.hilo_busy), 32'd0);
      check({tag, ".hi"}, u_if.hi, exp_hi);
      check({tag, ".lo"}, u_if.lo, exp_lo);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      #2;
      check("rst.busy", 32'(u_if.busy), 32'd0);
      check("rst.hilo_busy", 32'(u_if.hilo_busy), 32'd0);
      check("rst.hi", u_if.hi, 32'd0);
      check("rst.lo", u_if.lo, 32'd0);
      check("rst.md_out", u_if.md_out, 32'd0);
      drive(1'b1, 4'd1, 32'd3, 32'd4);
      #1;
      check("rst.hilo_busy_start", 32'(u_if.hilo_busy), 32'd1);
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Signed and unsigned multiply, back-to-back.
      run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      drive(1'b1, 4'd7, 32'd0, 32'd0);
      #1;
      check("mult.mfhi", u_if.md_out, 32'hFFFF_FFFF);
      run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
             32'h0000_0001, 32'hFFFF_FFFE);

      // Divides, including negative dividend and INT_MIN / -1.
      run_op("div", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h1, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
      run_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'h1, 32'hFFFF_FFFD, 32'h1, 32'h3);
      run_op("divneg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h1, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divmin", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
             32'h0, 32'h8000_0000);

      // mthi/mtlo then divide by zero leaves HI/LO alone.
      drive(1'b1, 4'd5, 32'h1234_5678, 32'd0);
      #1;
      check("mthi.hilo_busy", 32'(u_if.hilo_busy), 32'd0);
      tick();
      check("mthi.hi", u_if.hi, 32'h1234_5678);
      check("mthi.busy", 32'(u_if.busy), 32'd0);
      drive(1'b1, 4'd6, 32'h9ABC_DEF0, 32'd0);
      tick();
      check("mtlo.lo", u_if.lo, 32'h9ABC_DEF0);
      check("mtlo.hi", u_if.hi, 32'h1234_5678);
      run_op("div0", 4'd4, 32'd55, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0,
             32'h1234_5678, 32'h9ABC_DEF0);
      drive(1'b1, 4'd7, 32'd0, 32'd0);
      #1;
      check("div0.mfhi", u_if.md_out, 32'h1234_5678);
      drive(1'b1, 4'd8, 32'd0, 32'd0);
      #1;
      check("div0.mflo", u_if.md_out, 32'h9ABC_DEF0);
      drive(1'b1, 4'd9, 32'd0, 32'd0);
      #1;
      check("op9.md_out", u_if.md_out, 32'd0);
      check("op9.hilo_busy", 32'(u_if.hilo_busy), 32'd0);

      // Flushed mult and mthi have no effect.
      drive(1'b0, 4'd1, 32'd3, 32'd3);
      #1;
      check("flush.hilo_busy", 32'(u_if.hilo_busy), 32'd0);
      tick();
      check("flush.busy", 32'(u_if.busy), 32'd0);
      check("flush.lo", u_if.lo, 32'h9ABC_DEF0);
      drive(1'b0, 4'd5, 32'hDEAD_BEEF, 32'd0);
      tick();
      check("flush.hi", u_if.hi, 32'h1234_5678);

      // Async reset in the middle of a divide aborts it with no late write.
      drive(1'b1, 4'd3, 32'd100, 32'd7);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      tick();
      tick();
      check("abort.busy_pre", 32'(u_if.busy), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      check("abort.busy", 32'(u_if.busy), 32'd0);
      check("abort.hi", u_if.hi, 32'd0);
      check("abort.lo", u_if.lo, 32'd0);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("abort.no_write_hi", u_if.hi, 32'd0);
         check("abort.no_write_lo", u_if.lo, 32'd0);
         check("abort.idle", 32'(u_if.busy), 32'd0);
      end
      run_op("post_rst", 4'd1, 32'd6, 32'd7, 5, 32'd0, 32'd0, 32'd0, 32'd42);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
